// File: rtl/lockin_pkg.sv
// Shared constants, payload types and helpers for the lock-in demodulation channel.
package lockin_pkg;

    localparam int unsigned PHASE_W = 20;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned LUT_AW  = 10;
    localparam int unsigned IIR_W   = 48;
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned K_W     = 4;

    typedef logic        [PHASE_W-1:0] phase_t;
    typedef logic signed [DATA_W-1:0]  sample_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [IIR_W-1:0]   iir_t;
    typedef logic        [LUT_AW-1:0]  lut_addr_t;

    typedef struct packed {
        logic neg;
        logic mirror;
    } quad_t;

    // Quadrants 2/3 negate, quadrants 1/3 read the table backwards.
    function automatic quad_t quad_decode(input logic [1:0] q);
        quad_t r;
        r.neg    = q[1];
        r.mirror = q[0];
        return r;
    endfunction

    // Scale filter state back to sample width with clamping.
    function automatic sample_t sat_out(input iir_t s);
        iir_t t;
        t = s >>> 31;
        if (t > iir_t'(32767)) begin
            t = iir_t'(32767);
        end else if (t < -iir_t'(32768)) begin
            t = -iir_t'(32768);
        end
        return DATA_W'(t);
    endfunction

endpackage

// File: rtl/lockin_demod_channel_quarter_sine_rom.sv
// Dual-read synchronous quarter-wave sine ROM, contents computed at elaboration.
module quarter_sine_rom
    import lockin_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  lut_addr_t         addr_a,
    input  lut_addr_t         addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    localparam int unsigned DEPTH = 2 ** LUT_AW;

    // Taylor series keeps the table a pure elaboration-time constant.
    function automatic int rom_val(input int i);
        real x;
        real term;
        real acc;
        x    = 1.5707963267948966 * (real'(i) + 0.5) / real'(DEPTH);
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return $rtoi(32767.0 * acc + 0.5);
    endfunction

    logic [DATA_W-1:0] rom_w [DEPTH];

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
        localparam logic [DATA_W-1:0] VAL = DATA_W'(rom_val(i));
        assign rom_w[i] = VAL;
    end

    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;

    always_comb begin
        data_a_d = rom_w[addr_a];
        data_b_d = rom_w[addr_b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a = data_a_q;
    assign data_b = data_b_q;

endmodule

// File: rtl/lockin_demod_channel.sv
// One lock-in channel: phase accumulator, sin/cos reference, mixers and IIR low-pass.
module lockin_demod_channel
    import lockin_pkg::*;
(
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [PHASE_W-1:0] phase_incr,
    input  logic [PHASE_W-1:0] phase_offs,
    input  logic [K_W-1:0]     tau_shift,
    input  logic               phase_clr,
    input  logic [DATA_W-1:0]  sample_in,
    input  logic               sample_valid,
    output logic [DATA_W-1:0]  x_out,
    output logic [DATA_W-1:0]  y_out,
    output logic               xy_valid
);

    phase_t         acc_q, acc_d, p_q, p_d, acc_base;
    sample_t        smp1_q, smp1_d, smp2_q, smp2_d, smp3_q, smp3_d;
    logic [K_W-1:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d, k4_q, k4_d;
    logic           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic           neg_s2_q, neg_s2_d, neg_c2_q, neg_c2_d;
    sample_t        sin3_q, sin3_d, cos3_q, cos3_d;
    prod_t          px4_q, px4_d, py4_q, py4_d;
    iir_t           sx_q, sx_d, sy_q, sy_d, sx_n, sy_n, tgt_x, tgt_y;
    sample_t        x_out_q, x_out_d, y_out_q, y_out_d;
    logic           xy_valid_q, xy_valid_d;
    quad_t          qs, qc;
    lut_addr_t      a, addr_s, addr_c;
    logic [DATA_W-1:0] rom_s, rom_c;

    quarter_sine_rom u_rom (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .addr_a (addr_s),
        .addr_b (addr_c),
        .data_a (rom_s),
        .data_b (rom_c)
    );

    always_comb begin
        // Stage 1: phase accumulate; a coincident clear restarts from zero.
        acc_base = phase_clr ? '0 : acc_q;
        acc_d    = sample_valid ? phase_t'(acc_base + phase_incr) : acc_base;
        p_d      = phase_t'(acc_base + phase_offs);
        smp1_d   = sample_t'(sample_in);
        k1_d     = tau_shift;
        v1_d     = sample_valid;

        // Stage 2: quadrant decode drives the ROM addresses.
        qs       = quad_decode(p_q[PHASE_W-1 -: 2]);
        qc       = quad_decode(2'(p_q[PHASE_W-1 -: 2] + 2'd1));
        a        = p_q[PHASE_W-3 -: LUT_AW];
        addr_s   = qs.mirror ? ~a : a;
        addr_c   = qc.mirror ? ~a : a;
        neg_s2_d = qs.neg;
        neg_c2_d = qc.neg;
        smp2_d   = smp1_q;
        k2_d     = k1_q;
        v2_d     = v1_q;

        // Stage 3: apply quadrant sign.
        sin3_d   = neg_s2_q ? -sample_t'(rom_s) : sample_t'(rom_s);
        cos3_d   = neg_c2_q ? -sample_t'(rom_c) : sample_t'(rom_c);
        smp3_d   = smp2_q;
        k3_d     = k2_q;
        v3_d     = v2_q;

        // Stage 4: mixers.
        px4_d    = prod_t'(smp3_q) * prod_t'(sin3_q);
        py4_d    = prod_t'(smp3_q) * prod_t'(cos3_q);
        k4_d     = k3_q;
        v4_d     = v3_q;

        // Stage 5: single-cycle IIR update so back-to-back samples chain correctly.
        tgt_x      = iir_t'(px4_q) <<< 16;
        tgt_y      = iir_t'(py4_q) <<< 16;
        sx_n       = sx_q + ((tgt_x - sx_q) >>> k4_q);
        sy_n       = sy_q + ((tgt_y - sy_q) >>> k4_q);
        sx_d       = sx_q;
        sy_d       = sy_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        xy_valid_d = v4_q;
        if (v4_q) begin
            sx_d    = sx_n;
            sy_d    = sy_n;
            x_out_d = sat_out(sx_n);
            y_out_d = sat_out(sy_n);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc_q      <= '0;
            p_q        <= '0;
            smp1_q     <= '0;
            smp2_q     <= '0;
            smp3_q     <= '0;
            k1_q       <= '0;
            k2_q       <= '0;
            k3_q       <= '0;
            k4_q       <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            v4_q       <= 1'b0;
            neg_s2_q   <= 1'b0;
            neg_c2_q   <= 1'b0;
            sin3_q     <= '0;
            cos3_q     <= '0;
            px4_q      <= '0;
            py4_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            xy_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            p_q        <= p_d;
            smp1_q     <= smp1_d;
            smp2_q     <= smp2_d;
            smp3_q     <= smp3_d;
            k1_q       <= k1_d;
            k2_q       <= k2_d;
            k3_q       <= k3_d;
            k4_q       <= k4_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            v4_q       <= v4_d;
            neg_s2_q   <= neg_s2_d;
            neg_c2_q   <= neg_c2_d;
            sin3_q     <= sin3_d;
            cos3_q     <= cos3_d;
            px4_q      <= px4_d;
            py4_q      <= py4_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            xy_valid_q <= xy_valid_d;
        end
    end

    assign x_out    = x_out_q;
    assign y_out    = y_out_q;
    assign xy_valid = xy_valid_q;

endmodule

// File: tb/tb_lockin_demod_channel.sv
// Self-checking bench: directed scenarios plus random traffic against a real-valued reference model.
module tb_lockin_demod_channel;

    localparam real PI = 3.14159265358979323846;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [19:0] phase_incr = '0;
    logic [19:0] phase_offs = '0;
    logic [3:0]  tau_shift = '0;
    logic        phase_clr = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic        xy_valid;

    lockin_demod_channel dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .phase_incr    (phase_incr),
        .phase_offs    (phase_offs),
        .tau_shift     (tau_shift),
        .phase_clr     (phase_clr),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .x_out         (x_out),
        .y_out         (y_out),
        .xy_valid      (xy_valid)
    );

    initial forever #5 clk_clk = ~clk_clk;

    typedef struct {
        int due;
        int x;
        int y;
    } exp_t;

    exp_t        sb[$];
    int          got_x[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_x, last_y, prev_y, first_valid_cyc, c0;
    bit          mono;
    logic [19:0] m_acc = '0;
    longint      m_sx = 0;
    longint      m_sy = 0;
    int          wrap_exp[4] = '{24, 32766, -25, -32767};

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference sine/cosine: full-wave sample at the centre of the 12-bit phase bin.
    function automatic int ref_wave(input logic [19:0] p, input bit is_cos);
        logic [11:0] j;
        real ang, v, m;
        j   = p[19:8];
        ang = 2.0 * PI * (real'(j) + 0.5) / 4096.0;
        v   = 32767.0 * (is_cos ? $cos(ang) : $sin(ang));
        m   = (v < 0.0) ? -v : v;
        return (v < 0.0) ? -$rtoi(m + 0.5) : $rtoi(m + 0.5);
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Present one cycle of inputs, update the model, then check outputs after the edge.
    task automatic step(input bit v, input int s, input bit clr);
        exp_t        e;
        logic [19:0] base, p;
        longint      px, py;
        sample_valid = v;
        sample_in    = 16'(s);
        phase_clr    = clr;
        if (v) begin
            base  = clr ? 20'd0 : m_acc;
            p     = base + phase_offs;
            m_acc = base + phase_incr;
            px    = longint'(s) * longint'(ref_wave(p, 1'b0));
            py    = longint'(s) * longint'(ref_wave(p, 1'b1));
            m_sx  = m_sx + (((px * 65536) - m_sx) >>> tau_shift);
            m_sy  = m_sy + (((py * 65536) - m_sy) >>> tau_shift);
            e.due = cyc + 5;
            e.x   = clamp16(m_sx >>> 31);
            e.y   = clamp16(m_sy >>> 31);
            sb.push_back(e);
        end else if (clr) begin
            m_acc = '0;
        end
        @(posedge clk_clk);
        #1;
        cyc++;
        sample_valid = 1'b0;
        phase_clr    = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("xy_valid_hi", int'(xy_valid), 1);
            chk("x_out", int'($signed(x_out)), e.x);
            chk("y_out", int'($signed(y_out)), e.y);
            if (xy_valid === 1'b1) begin
                last_x = int'($signed(x_out));
                last_y = int'($signed(y_out));
                got_x.push_back(last_x);
                if (last_y < prev_y) mono = 1'b0;
                prev_y = last_y;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
        end else begin
            chk("xy_valid_lo", int'(xy_valid), 0);
        end
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        sample_valid  = 1'b0;
        phase_clr     = 1'b0;
        #1;
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_v", int'(xy_valid), 0);
        sb.delete();
        m_acc = '0;
        m_sx  = 0;
        m_sy  = 0;
        @(posedge clk_clk);
        #1;
        cyc++;
        reset_reset_n = 1'b1;
    endtask

    initial begin
        last_x = -99999;
        last_y = -99999;
        prev_y = -99999;
        first_valid_cyc = -1;
        mono = 1'b1;

        // Reset held, then idle after release.
        repeat (2) @(posedge clk_clk);
        #1;
        chk("por_x", int'(x_out), 0);
        chk("por_y", int'(y_out), 0);
        chk("por_v", int'(xy_valid), 0);
        reset_reset_n = 1'b1;
        repeat (100) step(1'b0, 0, 1'b0);

        // Bypass DC.
        phase_incr = 20'd0;
        phase_offs = 20'd0;
        tau_shift  = 4'd0;
        c0 = cyc;
        first_valid_cyc = -1;
        step(1'b1, 16384, 1'b0);
        repeat (6) step(1'b0, 0, 1'b0);
        chk("dc_x", last_x, 12);
        chk("dc_y", last_y, 16383);
        chk("dc_latency", first_valid_cyc - c0, 5);

        // Step response with k=4.
        do_reset();
        tau_shift = 4'd4;
        last_y = -99999;
        step(1'b1, 16384, 1'b0);
        repeat (5) step(1'b0, 0, 1'b0);
        chk("step_first_y", last_y, 1023);
        mono   = 1'b1;
        prev_y = last_y;
        repeat (300) step(1'b1, 16384, 1'b0);
        repeat (5) step(1'b0, 0, 1'b0);
        chk("step_monotonic", int'(mono), 1);
        chk("step_settle", last_y, 16383);

        // Quarter-turn wrap sequence.
        do_reset();
        phase_incr = 20'h40000;
        phase_offs = 20'd0;
        tau_shift  = 4'd0;
        got_x.delete();
        repeat (8) step(1'b1, 32767, 1'b0);
        repeat (5) step(1'b0, 0, 1'b0);
        chk("wrap_count", got_x.size(), 8);
        for (int i = 0; i < got_x.size() && i < 8; i++) chk("wrap_x", got_x[i], wrap_exp[i % 4]);

        // Phase clear coincident with a sample, then the following sample.
        phase_incr = 20'h12345;
        phase_offs = 20'h40000;
        repeat (3) step(1'b1, 1000, 1'b0);
        last_x = -99999;
        step(1'b1, 32767, 1'b1);
        repeat (5) step(1'b0, 0, 1'b0);
        chk("clr_x", last_x, 32766);
        step(1'b1, 32767, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, -20000, 1'b0);
        repeat (6) step(1'b0, 0, 1'b0);

        // Random traffic with parameter changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) tau_shift = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) phase_incr = 20'($urandom);
            if ($urandom_range(0, 63) == 0) phase_offs = 20'($urandom);
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 15) == 0);
        end
        repeat (6) step(1'b0, 0, 1'b0);

        // Reset mid-stream flushes in-flight samples.
        tau_shift = 4'd2;
        repeat (3) step(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0);
        do_reset();
        first_valid_cyc = -1;
        c0 = cyc;
        repeat (8) step(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0);
        repeat (5) step(1'b0, 0, 1'b0);
        chk("rst_latency", first_valid_cyc - c0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
